// File: rtl/ic_bvmul_sge_sweep_checker_if.sv
// Bus between the exhaustive sweep checker and the IC circuit under test.
// The checker drives candidates and reports results; the environment supplies
// the start request and the circuit's combinational verdict.
interface ic_bvmul_sge_sweep_checker_if #(
    parameter int W = 4
);
    logic             start;
    logic [2*W-1:0]   st_o;
    logic             ic_i;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2*W:0]     mismatch_cnt;
    logic             first_fail_valid;
    logic [2*W-1:0]   first_fail;

    // Checker side
    modport master (
        input  start,
        input  ic_i,
        output st_o,
        output busy,
        output done,
        output pass,
        output mismatch_cnt,
        output first_fail_valid,
        output first_fail
    );

    // Environment / IC circuit side
    modport slave (
        output start,
        output ic_i,
        input  st_o,
        input  busy,
        input  done,
        input  pass,
        input  mismatch_cnt,
        input  first_fail_valid,
        input  first_fail
    );
endinterface

// File: rtl/ic_bvmul_sge_sweep_checker.sv
// Exhaustive checker for an invertibility-condition circuit of signed s*x >= t.
// For each {s,t} candidate it sweeps every x to find the ground truth
// (exists x such that s*x >=s t), then compares against the circuit verdict.
module ic_bvmul_sge_sweep_checker #(
    parameter int W = 4
) (
    input  logic clk,
    input  logic rst,
    ic_bvmul_sge_sweep_checker_if.master bus
);
    localparam int PW = 2 * W;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        COMPARE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   st_q, st_d;
    logic [W-1:0]    x_q, x_d;
    logic            found_q, found_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [CW-1:0]   mismatch_cnt_q, mismatch_cnt_d;
    logic            first_fail_valid_q, first_fail_valid_d;
    logic [PW-1:0]   first_fail_q, first_fail_d;

    logic [W-1:0]    s_cur;
    logic [W-1:0]    t_cur;
    logic [W-1:0]    prod;
    logic            ge;

    assign s_cur = st_q[PW-1:W];
    assign t_cur = st_q[W-1:0];
    // W-bit product: the truncation to W bits is the modular multiply
    assign prod  = x_q * s_cur;
    assign ge    = $signed(prod) >= $signed(t_cur);

    // Next-state logic: sweep x per candidate, then compare and advance the candidate
    always_comb begin
        state_d            = state_q;
        st_d               = st_q;
        x_d                = x_q;
        found_d            = found_q;
        busy_d             = busy_q;
        done_d             = done_q;
        pass_d             = pass_q;
        mismatch_cnt_d     = mismatch_cnt_q;
        first_fail_valid_d = first_fail_valid_q;
        first_fail_d       = first_fail_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d            = SWEEP;
                    st_d               = '0;
                    x_d                = '0;
                    found_d            = 1'b0;
                    busy_d             = 1'b1;
                    done_d             = 1'b0;
                    pass_d             = 1'b0;
                    mismatch_cnt_d     = '0;
                    first_fail_valid_d = 1'b0;
                    first_fail_d       = '0;
                end
            end
            SWEEP: begin
                found_d = found_q | ge;
                if (x_q == {W{1'b1}}) begin
                    state_d = COMPARE;
                end else begin
                    x_d = x_q + W'(1);
                end
            end
            COMPARE: begin
                if (bus.ic_i != found_q) begin
                    mismatch_cnt_d = mismatch_cnt_q + CW'(1);
                    if (!first_fail_valid_q) begin
                        first_fail_valid_d = 1'b1;
                        first_fail_d       = st_q;
                    end
                end
                if (st_q == {PW{1'b1}}) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mismatch_cnt_d == '0);
                end else begin
                    state_d = SWEEP;
                    st_d    = st_q + PW'(1);
                    x_d     = '0;
                    found_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep and discards results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            st_q               <= '0;
            x_q                <= '0;
            found_q            <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            mismatch_cnt_q     <= '0;
            first_fail_valid_q <= 1'b0;
            first_fail_q       <= '0;
        end else begin
            state_q            <= state_d;
            st_q               <= st_d;
            x_q                <= x_d;
            found_q            <= found_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            pass_q             <= pass_d;
            mismatch_cnt_q     <= mismatch_cnt_d;
            first_fail_valid_q <= first_fail_valid_d;
            first_fail_q       <= first_fail_d;
        end
    end

    assign bus.st_o             = st_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.mismatch_cnt     = mismatch_cnt_q;
    assign bus.first_fail_valid = first_fail_valid_q;
    assign bus.first_fail       = first_fail_q;

endmodule
